// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle plus the slice bus to the external 16-bit adder core.
interface wide_add_sequencer_if #(
  parameter int unsigned NWORDS = 4
);
  localparam int unsigned W = 16 * NWORDS;

  // Operand side
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;

  // Result side
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  // Adder core slice bus
  logic [15:0]  add_a;
  logic [15:0]  add_b;
  logic         add_cin;
  logic [15:0]  add_sum;
  logic         add_cout;

  // Sequencer side
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin
  );

  // Environment side: operand producer, result consumer and adder core
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Wide adder built by streaming 16-bit slices, LSW first, through one external adder core,
// rippling the core carry-out into the next slice. Valid/ready on both operand and result side.
module wide_add_sequencer #(
  parameter int unsigned NWORDS = 4
) (
  input logic                 clk,
  input logic                 rst,
  wide_add_sequencer_if.slave bus
);
  localparam int unsigned W  = 16 * NWORDS;
  localparam int unsigned IW = $clog2(NWORDS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_last;
  logic            w_done;
  logic            w_run;
  logic [IW+3:0]   w_lsb;

  // Bit offset of the slice currently in the core
  assign w_lsb  = {r_idx, 4'b0000};
  assign w_last = (r_idx == IW'(NWORDS - 1));
  assign w_done = (r_state == StDone);
  assign w_run  = (r_state == StRun);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next state and operand-side ready; DONE can retire and accept on the same edge
  always_comb begin
    w_state_d  = r_state;
    w_in_ready = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_d = StRun;
      end
      StRun: begin
        if (w_last) w_state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          w_in_ready = 1'b1;
          w_state_d  = bus.in_valid ? StRun : StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_accept     = bus.in_valid & w_in_ready;
  assign bus.in_ready = w_in_ready;

  // Operand capture on acceptance; one slice per cycle while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.in_a;
      r_b     <= bus.in_b;
      r_carry <= bus.in_cin;
      r_idx   <= '0;
    end else if (w_run) begin
      r_sum[w_lsb +: 16] <= bus.add_sum;
      r_carry            <= bus.add_cout;
      r_idx              <= w_last ? '0 : r_idx + IW'(1);
    end
  end

  // Core feed is quiet outside RUN; results are only shown while valid
  always_comb begin
    bus.add_a     = w_run ? r_a[w_lsb +: 16] : 16'h0000;
    bus.add_b     = w_run ? r_b[w_lsb +: 16] : 16'h0000;
    bus.add_cin   = w_run & r_carry;
    bus.out_valid = w_done;
    bus.out_sum   = w_done ? r_sum : '0;
    bus.out_cout  = w_done & r_carry;
    bus.out_ovf   = w_done & (r_a[W-1] == r_b[W-1]) & (r_sum[W-1] != r_a[W-1]);
  end
endmodule
